// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM arbiter: FSM state encoding, bus owner
// codes and default bus widths.
package vram_pkg;

   localparam int DEF_ADDR_WIDTH = 16;
   localparam int DEF_DATA_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   typedef enum logic {
      OWN_MPU = 1'b0,
      OWN_REN = 1'b1
   } owner_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of the requester handshakes, blanking flags and VRAM pin signals
// around the arbiter. The slave modport is the arbiter's view; the master
// modport is the surrounding system (MPU, renderer, display timing, pins).
interface vram_arbiter_if
   import vram_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

   logic                  hblank;
   logic                  vblank;

   logic                  mpu_req;
   logic                  mpu_wr;
   logic [1:0]            mpu_be;
   logic [ADDR_WIDTH-1:0] mpu_addr;
   logic [DATA_WIDTH-1:0] mpu_wdata;
   logic                  mpu_ack;
   logic [DATA_WIDTH-1:0] mpu_rdata;

   logic                  ren_req;
   logic [ADDR_WIDTH-1:0] ren_addr;
   logic                  ren_ack;
   logic [DATA_WIDTH-1:0] ren_rdata;

   logic                  _vram_en;
   logic                  _vram_rd;
   logic                  _vram_wr;
   logic [1:0]            _vram_be;
   logic [ADDR_WIDTH-1:0] vram_addr;
   logic [DATA_WIDTH-1:0] vram_data_out;
   logic                  vram_data_oe;
   logic [DATA_WIDTH-1:0] vram_data_in;

   modport slave (
      input  hblank, vblank,
      input  mpu_req, mpu_wr, mpu_be, mpu_addr, mpu_wdata,
      output mpu_ack, mpu_rdata,
      input  ren_req, ren_addr,
      output ren_ack, ren_rdata,
      output _vram_en, _vram_rd, _vram_wr, _vram_be,
      output vram_addr, vram_data_out, vram_data_oe,
      input  vram_data_in
   );

   modport master (
      output hblank, vblank,
      output mpu_req, mpu_wr, mpu_be, mpu_addr, mpu_wdata,
      input  mpu_ack, mpu_rdata,
      output ren_req, ren_addr,
      input  ren_ack, ren_rdata,
      input  _vram_en, _vram_rd, _vram_wr, _vram_be,
      input  vram_addr, vram_data_out, vram_data_oe,
      output vram_data_in
   );

endinterface

// File: rtl/vram_arb_priority.sv
// Grant decision for the VRAM arbiter. The renderer wins contention during
// active display, the MPU wins during blanking. With VRAM_ARB_STARVE_GUARD_EN
// defined, a saturating wait counter forces an MPU win after STARVE_LIMIT
// contended renderer grants.
module vram_arb_priority
   import vram_pkg::*;
#(
   parameter int STARVE_LIMIT = 8
)
(
   input  logic   clk,
   input  logic   reset,
   input  logic   arb_en_i,
   input  logic   mpu_req_i,
   input  logic   ren_req_i,
   input  logic   hblank_i,
   input  logic   vblank_i,
   output logic   grant_o,
   output owner_e owner_o
);

   logic guard_trip;

`ifdef VRAM_ARB_STARVE_GUARD_EN
   localparam int                WAIT_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

   logic [WAIT_W-1:0] wait_q;
   logic [WAIT_W-1:0] wait_d;

   // Charge the MPU's wait on each renderer win it lost, clear it on MPU wins.
   always_comb begin
      // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
      wait_d = wait_q;
      if (grant_o) begin
         if (owner_o == OWN_MPU) begin
            wait_d = '0;
         end else if (mpu_req_i && (wait_q != WAIT_MAX)) begin
            wait_d = wait_q + 1'b1;
         end
      end
   end

   // Wait counter register.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (reset) begin
         wait_q <= '0;
      end else begin
         wait_q <= wait_d;
      end
   end

   assign guard_trip = (wait_q == WAIT_MAX);
`else
   logic unused_guard;
   assign unused_guard = ^{clk, reset};
   assign guard_trip   = 1'b0;
`endif

   // Pick the winner of the current IDLE cycle.
   always_comb begin
      grant_o = arb_en_i & (mpu_req_i | ren_req_i);
      owner_o = OWN_MPU;
      if (ren_req_i && !mpu_req_i) begin
         owner_o = OWN_REN;
      end else if (ren_req_i && mpu_req_i && !guard_trip && !hblank_i && !vblank_i) begin
         owner_o = OWN_REN;
      end
   end

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares the single external VRAM port between the MPU and
// the renderer. Each grant runs one fixed-length access (ACCESS_CYCLES
// cycles of strobes) followed by a turnaround cycle that pulses the
// winner's ack. All outputs are registered.
// Optional feature: VRAM_ARB_STARVE_GUARD_EN enables the MPU starvation
// guard inside vram_arb_priority.
// The interface instance must be built with the same ADDR_WIDTH/DATA_WIDTH.
module vram_arbiter
   import vram_pkg::*;
#(
   parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int ACCESS_CYCLES = 2,
   parameter int STARVE_LIMIT  = 8
)
(
   input logic           clk,
   input logic           reset,
   vram_arbiter_if.slave bus
);

   localparam int               CNT_W    = $clog2(ACCESS_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES);

   state_e                state_q;
   owner_e                owner_q;
   logic [CNT_W-1:0]      cnt_q;

   logic                  vram_en_n_q;
   logic                  vram_rd_n_q;
   logic                  vram_wr_n_q;
   logic [1:0]            vram_be_n_q;
   logic [ADDR_WIDTH-1:0] vram_addr_q;
   logic [DATA_WIDTH-1:0] vram_data_out_q;
   logic                  vram_data_oe_q;

   logic                  mpu_ack_q;
   logic                  ren_ack_q;
   logic [DATA_WIDTH-1:0] mpu_rdata_q;
   logic [DATA_WIDTH-1:0] ren_rdata_q;

   logic                  grant;
   owner_e                grant_owner;

   vram_arb_priority #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_priority (
      .clk       (clk),
      .reset     (reset),
      .arb_en_i  (state_q == IDLE),
      .mpu_req_i (bus.mpu_req),
      .ren_req_i (bus.ren_req),
      .hblank_i  (bus.hblank),
      .vblank_i  (bus.vblank),
      .grant_o   (grant),
      .owner_o   (grant_owner)
   );

   // Access FSM: latch the winner's command onto the bus registers at grant,
   // hold strobes through ACCESS, release the bus and pulse ack in DONE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         owner_q         <= OWN_MPU;
         cnt_q           <= '0;
         vram_en_n_q     <= 1'b1;
         vram_rd_n_q     <= 1'b1;
         vram_wr_n_q     <= 1'b1;
         vram_be_n_q     <= 2'b11;
         vram_addr_q     <= '0;
         vram_data_out_q <= '0;
         vram_data_oe_q  <= 1'b0;
         mpu_ack_q       <= 1'b0;
         ren_ack_q       <= 1'b0;
         mpu_rdata_q     <= '0;
         ren_rdata_q     <= '0;
      end else begin
         mpu_ack_q <= 1'b0;
         ren_ack_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant) begin
                  state_q     <= ACCESS;
                  owner_q     <= grant_owner;
                  cnt_q       <= CNT_W'(1);
                  vram_en_n_q <= 1'b0;
                  if (grant_owner == OWN_MPU) begin
                     vram_addr_q     <= bus.mpu_addr;
                     vram_be_n_q     <= ~bus.mpu_be;
                     vram_rd_n_q     <= bus.mpu_wr;
                     vram_wr_n_q     <= ~bus.mpu_wr;
                     vram_data_oe_q  <= bus.mpu_wr;
                     vram_data_out_q <= bus.mpu_wdata;
                  end else begin
                     vram_addr_q    <= bus.ren_addr;
                     vram_be_n_q    <= 2'b00;
                     vram_rd_n_q    <= 1'b0;
                     vram_wr_n_q    <= 1'b1;
                     vram_data_oe_q <= 1'b0;
                  end
               end
            end

            ACCESS: begin
               if (cnt_q == CNT_LAST) begin
                  state_q        <= DONE;
                  vram_en_n_q    <= 1'b1;
                  vram_rd_n_q    <= 1'b1;
                  vram_wr_n_q    <= 1'b1;
                  vram_be_n_q    <= 2'b11;
                  vram_data_oe_q <= 1'b0;
                  if (owner_q == OWN_MPU) begin
                     mpu_ack_q <= 1'b1;
                     if (!vram_rd_n_q) mpu_rdata_q <= bus.vram_data_in;
                  end else begin
                     ren_ack_q <= 1'b1;
                     if (!vram_rd_n_q) ren_rdata_q <= bus.vram_data_in;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            DONE: begin
               state_q <= IDLE;
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus._vram_en      = vram_en_n_q;
   assign bus._vram_rd      = vram_rd_n_q;
   assign bus._vram_wr      = vram_wr_n_q;
   assign bus._vram_be      = vram_be_n_q;
   assign bus.vram_addr     = vram_addr_q;
   assign bus.vram_data_out = vram_data_out_q;
   assign bus.vram_data_oe  = vram_data_oe_q;
   assign bus.mpu_ack       = mpu_ack_q;
   assign bus.mpu_rdata     = mpu_rdata_q;
   assign bus.ren_ack       = ren_ack_q;
   assign bus.ren_rdata     = ren_rdata_q;

endmodule
